// File: rtl/mask_seq_ctrl_pkg.sv
// Shared constants for the 3x3 window mask sequencer and the mask stage it drives.
package mask_seq_ctrl_pkg;

   localparam int unsigned DIM_W_DEF  = 8;
   localparam int unsigned PASS_W_DEF = 10;

   // Tap bus geometry shared with the mask stage; tap 0 is the centre tap.
   localparam int unsigned TAP_W = 10;
   localparam int unsigned TAP_N = 9;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic MODE_PW = 1'b0;
   localparam logic MODE_DW = 1'b1;

endpackage

// File: rtl/mask_seq_ctrl_raster_counter.sv
// Raster-order column/row counter with a flag marking the last pixel of the image.
module mask_seq_ctrl_raster_counter #(
   parameter int unsigned DIM_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic             advance,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last_pix
);

   logic last_col;
   logic last_row;

   assign last_col = (col == width - DIM_W'(1));
   assign last_row = (row == height - DIM_W'(1));
   assign last_pix = last_col && last_row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clear || load) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + DIM_W'(1);
         end else begin
            col <= col + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/mask_seq_ctrl.sv
// Window sequencer for the 3x3 mask stage: scans raster pixel streams over several
// passes and presents each completed window's top-left position to the datapath.
module mask_seq_ctrl
   import mask_seq_ctrl_pkg::*;
#(
   parameter int unsigned DIM_W  = DIM_W_DEF,
   parameter int unsigned PASS_W = PASS_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_clear,
   input  logic              i_mode,
   input  logic [DIM_W-1:0]  i_img_w,
   input  logic [DIM_W-1:0]  i_img_h,
   input  logic [PASS_W-1:0] i_num_pass,
   input  logic              i_pix_valid,
   output logic              o_pix_ready,
   output logic              o_win_valid,
   input  logic              i_win_ready,
   output logic [DIM_W-1:0]  o_win_row,
   output logic [DIM_W-1:0]  o_win_col,
   output logic              o_win_last,
   output logic              o_mask,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   logic [1:0]        state;
   logic              mode;
   logic [DIM_W-1:0]  img_w;
   logic [DIM_W-1:0]  img_h;
   logic [PASS_W-1:0] num_pass;
   logic [PASS_W-1:0] pass;
   logic              err;

   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  col;
   logic              last_pix;
   logic              cfg_bad;
   logic              start_ok;
   logic              accept;
   logic              win_gen;
   logic              win_hs;
   logic [DIM_W-1:0]  win_off;

   assign cfg_bad = (i_num_pass == '0) || (i_img_w == '0) || (i_img_h == '0) ||
                    ((i_mode == MODE_DW) && ((i_img_w < DIM_W'(3)) || (i_img_h < DIM_W'(3))));
   assign start_ok = (state == ST_IDLE) && i_start && !cfg_bad;

   // Single output register: a pending window may drain in the same cycle a new one loads.
   assign o_pix_ready = (state == ST_RUN) && (!o_win_valid || i_win_ready);
   assign accept      = i_pix_valid && o_pix_ready;
   assign win_hs      = o_win_valid && i_win_ready;
   assign win_gen     = accept && ((mode == MODE_PW) || ((row >= DIM_W'(2)) && (col >= DIM_W'(2))));
   assign win_off     = (mode == MODE_PW) ? '0 : DIM_W'(2);

   assign o_mask = mode;
   assign o_busy = (state != ST_IDLE);
   assign o_done = (state == ST_DONE);
   assign o_err  = err;

   mask_seq_ctrl_raster_counter #(
      .DIM_W (DIM_W)
   ) u_raster (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clear    (i_clear),
      .load     (start_ok),
      .advance  (accept),
      .width    (img_w),
      .height   (img_h),
      .row      (row),
      .col      (col),
      .last_pix (last_pix)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         mode        <= 1'b0;
         img_w       <= '0;
         img_h       <= '0;
         num_pass    <= '0;
         pass        <= '0;
         err         <= 1'b0;
         o_win_valid <= 1'b0;
         o_win_row   <= '0;
         o_win_col   <= '0;
         o_win_last  <= 1'b0;
      end else if (i_clear) begin
         // Abort keeps the latched config and mask; only job progress is dropped.
         state       <= ST_IDLE;
         pass        <= '0;
         err         <= 1'b0;
         o_win_valid <= 1'b0;
         o_win_row   <= '0;
         o_win_col   <= '0;
         o_win_last  <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  if (cfg_bad) begin
                     err <= 1'b1;
                  end else begin
                     mode     <= i_mode;
                     img_w    <= i_img_w;
                     img_h    <= i_img_h;
                     num_pass <= i_num_pass;
                     pass     <= '0;
                     state    <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (accept && last_pix) begin
                  pass  <= pass + PASS_W'(1);
                  state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (win_hs) state <= (pass < num_pass) ? ST_RUN : ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase

         if (win_gen) begin
            o_win_valid <= 1'b1;
            o_win_row   <= row - win_off;
            o_win_col   <= col - win_off;
            o_win_last  <= last_pix;
         end else if (win_hs) begin
            o_win_valid <= 1'b0;
            o_win_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mask_seq_ctrl.sv
// Randomised bench for mask_seq_ctrl: expected window lists are built per job from the
// image geometry and compared against every window handshake.
module tb_mask_seq_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_start = 1'b0;
   logic       i_clear = 1'b0;
   logic       i_mode = 1'b0;
   logic [7:0] i_img_w = '0;
   logic [7:0] i_img_h = '0;
   logic [9:0] i_num_pass = '0;
   logic       i_pix_valid = 1'b0;
   logic       o_pix_ready;
   logic       o_win_valid;
   logic       i_win_ready = 1'b0;
   logic [7:0] o_win_row;
   logic [7:0] o_win_col;
   logic       o_win_last;
   logic       o_mask;
   logic       o_busy;
   logic       o_done;
   logic       o_err;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] c;
      logic       l;
   } win_t;

   int n_chk = 0;
   int n_pass = 0;

   mask_seq_ctrl u_dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_clear     (i_clear),
      .i_mode      (i_mode),
      .i_img_w     (i_img_w),
      .i_img_h     (i_img_h),
      .i_num_pass  (i_num_pass),
      .i_pix_valid (i_pix_valid),
      .o_pix_ready (o_pix_ready),
      .o_win_valid (o_win_valid),
      .i_win_ready (i_win_ready),
      .o_win_row   (o_win_row),
      .o_win_col   (o_win_col),
      .o_win_last  (o_win_last),
      .o_mask      (o_mask),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_pix_ready"}, 32'(o_pix_ready), 32'd0);
      chk({tag, "_win_valid"}, 32'(o_win_valid), 32'd0);
      chk({tag, "_win_last"}, 32'(o_win_last), 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_err"}, 32'(o_err), 32'd0);
   endtask

   task automatic start_job(input logic m, input int w, input int h, input int np);
      i_mode     = m;
      i_img_w    = 8'(w);
      i_img_h    = 8'(h);
      i_num_pass = 10'(np);
      i_start    = 1'b1;
      @(posedge i_clk); #1;
      i_start    = 1'b0;
      // Scramble config after the start edge; the DUT must have latched its copy.
      i_mode     = 1'($urandom_range(1));
      i_img_w    = 8'($urandom_range(255));
      i_img_h    = 8'($urandom_range(255));
      i_num_pass = 10'($urandom_range(1023));
   endtask

   task automatic run_job(input logic m, input int w, input int h, input int np,
                          input int vp, input int rp, input int stall_idx);
      win_t q[$];
      win_t e;
      int   total, popped, accepts, cyc, last_acc, stall_left;
      bit   got_done, pv, pr, pl;
      logic [7:0] prw, pcl;
      for (int p = 0; p < np; p++)
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
               if (!m || (r >= 2 && c >= 2)) begin
                  e.r = 8'(m ? r - 2 : r);
                  e.c = 8'(m ? c - 2 : c);
                  e.l = (r == h - 1) && (c == w - 1);
                  q.push_back(e);
               end
      total = q.size();
      popped = 0; accepts = 0; cyc = 0; last_acc = 0; stall_left = 3;
      got_done = 0; pv = 0; pr = 0; pl = 0; prw = '0; pcl = '0;
      start_job(m, w, h, np);
      while (cyc < 5000) begin
         i_pix_valid = ($urandom_range(99) < vp);
         i_win_ready = ($urandom_range(99) < rp);
         if (stall_idx >= 0 && popped == stall_idx && o_win_valid && stall_left > 0) begin
            i_win_ready = 1'b0;
            stall_left--;
         end
         @(negedge i_clk);
         if (cyc == 0) begin
            chk("busy_run", 32'(o_busy), 32'd1);
            chk("mask_run", 32'(o_mask), 32'(m));
         end
         if (pv && !pr)
            chk("win_hold", {15'd0, o_win_valid, o_win_row, o_win_col, o_win_last},
                {15'd0, 1'b1, prw, pcl, pl});
         if (o_win_valid && !i_win_ready)
            chk("backpressure", 32'(o_pix_ready), 32'd0);
         if (o_win_valid && i_win_ready) begin
            if (q.size() == 0) begin
               chk("extra_win", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("win", {15'd0, o_win_row, o_win_col, o_win_last}, {15'd0, e.r, e.c, e.l});
            end
            popped++;
         end
         if (o_pix_ready && i_pix_valid) begin
            accepts++;
            if (accepts == w * h * np) last_acc = cyc;
         end
         pv = o_win_valid; pr = i_win_ready; prw = o_win_row; pcl = o_win_col; pl = o_win_last;
         if (o_done) begin
            got_done = 1;
            chk("done_no_win", 32'(o_win_valid), 32'd0);
            break;
         end
         cyc++;
         @(posedge i_clk); #1;
      end
      if (!got_done) chk("done_timeout", 32'd0, 32'd1);
      if (got_done && vp == 100 && rp == 100 && stall_idx < 0)
         chk("done_latency", 32'(cyc - last_acc), 32'd2);
      chk("win_count", 32'(popped), 32'(total));
      chk("pix_count", 32'(accepts), 32'(w * h * np));
      @(posedge i_clk); #1;
      i_pix_valid = 1'b0;
      i_win_ready = 1'b0;
      @(negedge i_clk);
      chk("idle_busy", 32'(o_busy), 32'd0);
      chk("idle_done", 32'(o_done), 32'd0);
      chk("idle_mask", 32'(o_mask), 32'(m));
      @(posedge i_clk); #1;
   endtask

   task automatic check_err(input logic m, input int w, input int h, input int np);
      start_job(m, w, h, np);
      @(negedge i_clk);
      chk("err_pulse", 32'(o_err), 32'd1);
      chk("err_busy", 32'(o_busy), 32'd0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("err_single", 32'(o_err), 32'd0);
      chk("err_busy2", 32'(o_busy), 32'd0);
      @(posedge i_clk); #1;
   endtask

   initial begin
      int m, w, h, np;
      #2;
      chk_quiet("rst");
      chk("rst_mask", 32'(o_mask), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      run_job(1'b0, 4, 2, 1, 100, 100, -1);
      run_job(1'b1, 4, 4, 2, 100, 100, -1);
      run_job(1'b1, 5, 3, 1, 100, 100, 1);
      check_err(1'b1, 2, 5, 1);
      check_err(1'b0, 4, 4, 0);

      // Abort after five accepts, then a fresh job must start from the origin.
      start_job(1'b1, 4, 4, 1);
      i_pix_valid = 1'b1;
      i_win_ready = 1'b1;
      repeat (5) @(posedge i_clk);
      #1;
      i_pix_valid = 1'b0;
      i_clear = 1'b1;
      @(posedge i_clk); #1;
      i_clear = 1'b0;
      @(negedge i_clk);
      chk_quiet("clr");
      chk("clr_mask", 32'(o_mask), 32'd1);
      @(posedge i_clk); #1;
      run_job(1'b1, 4, 4, 1, 100, 100, -1);

      for (int k = 0; k < 8; k++) begin
         m = int'($urandom_range(1));
         w = m ? int'($urandom_range(3, 7)) : int'($urandom_range(1, 6));
         h = m ? int'($urandom_range(3, 7)) : int'($urandom_range(1, 5));
         np = int'($urandom_range(1, 3));
         run_job(1'(m), w, h, np, int'($urandom_range(50, 100)),
                 int'($urandom_range(50, 100)), -1);
      end

      // Asynchronous reset while a window is pending.
      start_job(1'b1, 5, 5, 1);
      i_pix_valid = 1'b1;
      i_win_ready = 1'b0;
      repeat (13) @(posedge i_clk);
      #1;
      chk("pre_rst_valid", 32'(o_win_valid), 32'd1);
      i_rst_n = 1'b0;
      #1;
      chk_quiet("arst");
      chk("arst_mask", 32'(o_mask), 32'd0);
      chk("arst_row", 32'(o_win_row), 32'd0);
      i_pix_valid = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      run_job(1'b0, 3, 3, 1, 100, 100, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
